// File: rtl/de2_reset_ctrl.sv
// Board reset sequencer and push-button conditioner for the DE2 veriRISCV build.
// Keys are synchronized, debounced and edge-detected; the reset key drives the SoC reset FSM.
module de2_reset_ctrl #(
  parameter int NKEY              = 4,
  parameter int DEBOUNCE_CYCLES   = 500000,
  parameter int RESET_HOLD_CYCLES = 1024,
  parameter int RESET_KEY         = 0
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [NKEY-1:0] key_in,
  output logic            soc_rst,
  output logic [NKEY-1:0] key_level,
  output logic [NKEY-1:0] key_press,
  output logic [NKEY-1:0] key_release,
  output logic [7:0]      rst_cnt
);

  localparam int DW = $clog2(DEBOUNCE_CYCLES);
  localparam int HW = (RESET_HOLD_CYCLES > 1) ? $clog2(RESET_HOLD_CYCLES) : 1;

  typedef enum logic [1:0] {
    HOLD    = 2'd0,
    RUN     = 2'd1,
    PRESSED = 2'd2
  } state_e;

  logic [NKEY-1:0] sync1_q, sync2_q, pressed_s;
  logic [DW-1:0]   db_cnt_q [NKEY];
  logic [DW-1:0]   db_cnt_d [NKEY];
  logic [NKEY-1:0] key_level_q, key_level_d;
  logic [NKEY-1:0] key_press_q, key_press_d;
  logic [NKEY-1:0] key_release_q, key_release_d;

  state_e          state_q, state_d;
  logic [HW-1:0]   hold_cnt_q, hold_cnt_d;
  logic [7:0]      rst_cnt_q, rst_cnt_d;
  logic            soc_rst_q, soc_rst_d;

  // Synchronizer flops reset to 1 so a released key looks stable out of reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= '1;
      sync2_q <= '1;
    end else begin
      sync1_q <= key_in;
      sync2_q <= sync1_q;
    end
  end

  assign pressed_s = ~sync2_q;

  always_comb begin
    key_level_d   = key_level_q;
    key_press_d   = '0;
    key_release_d = '0;
    for (int i = 0; i < NKEY; i++) begin
      db_cnt_d[i] = '0;
      if (pressed_s[i] != key_level_q[i]) begin
        if (db_cnt_q[i] == DW'(DEBOUNCE_CYCLES - 1)) begin
          key_level_d[i]   = pressed_s[i];
          key_press_d[i]   = pressed_s[i];
          key_release_d[i] = ~pressed_s[i];
        end else begin
          db_cnt_d[i] = db_cnt_q[i] + DW'(1);
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NKEY; i++) begin
        db_cnt_q[i] <= '0;
      end
      key_level_q   <= '0;
      key_press_q   <= '0;
      key_release_q <= '0;
    end else begin
      for (int i = 0; i < NKEY; i++) begin
        db_cnt_q[i] <= db_cnt_d[i];
      end
      key_level_q   <= key_level_d;
      key_press_q   <= key_press_d;
      key_release_q <= key_release_d;
    end
  end

  // The FSM reacts to the combinational press/release so soc_rst moves on the pulse edge.
  always_comb begin
    state_d    = state_q;
    hold_cnt_d = hold_cnt_q;
    rst_cnt_d  = rst_cnt_q;
    case (state_q)
      HOLD: begin
        if (key_level_q[RESET_KEY] || key_press_d[RESET_KEY]) begin
          hold_cnt_d = '0;
        end else if (hold_cnt_q == HW'(RESET_HOLD_CYCLES - 1)) begin
          state_d    = RUN;
          hold_cnt_d = '0;
        end else begin
          hold_cnt_d = hold_cnt_q + HW'(1);
        end
      end
      RUN: begin
        if (key_press_d[RESET_KEY]) begin
          state_d = PRESSED;
          if (rst_cnt_q != 8'hFF) begin
            rst_cnt_d = rst_cnt_q + 8'd1;
          end
        end
      end
      PRESSED: begin
        if (key_release_d[RESET_KEY]) begin
          state_d    = HOLD;
          hold_cnt_d = '0;
        end
      end
      default: begin
        state_d    = HOLD;
        hold_cnt_d = '0;
      end
    endcase
    soc_rst_d = (state_d != RUN);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= HOLD;
      hold_cnt_q <= '0;
      rst_cnt_q  <= '0;
      soc_rst_q  <= 1'b1;
    end else begin
      state_q    <= state_d;
      hold_cnt_q <= hold_cnt_d;
      rst_cnt_q  <= rst_cnt_d;
      soc_rst_q  <= soc_rst_d;
    end
  end

  assign soc_rst     = soc_rst_q;
  assign key_level   = key_level_q;
  assign key_press   = key_press_q;
  assign key_release = key_release_q;
  assign rst_cnt     = rst_cnt_q;

endmodule

// File: tb/tb_de2_reset_ctrl.sv
// Testbench for de2_reset_ctrl: directed scenarios plus randomized key activity,
// compared every cycle against a window-based behavioural model.
module tb_de2_reset_ctrl;

  localparam int NKEY = 4;
  localparam int DB   = 4;
  localparam int HOLD = 8;
  localparam int RK   = 0;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic [NKEY-1:0] key_in = '1;
  logic            soc_rst;
  logic [NKEY-1:0] key_level, key_press, key_release;
  logic [7:0]      rst_cnt;

  int checks = 0;
  int failures = 0;

  // Reference model: a key level flips once the last DB synchronized samples all disagree
  // with it; the SoC runs once the reset key has been seen released for HOLD whole edges.
  logic [NKEY-1:0] raw1, raw2;
  logic [NKEY-1:0] pwin [DB];
  logic [NKEY-1:0] m_level, m_press, m_release;
  int              streak;
  int              m_cnt;
  logic            m_soc;

  de2_reset_ctrl #(
    .NKEY(NKEY),
    .DEBOUNCE_CYCLES(DB),
    .RESET_HOLD_CYCLES(HOLD),
    .RESET_KEY(RK)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .key_in(key_in),
    .soc_rst(soc_rst),
    .key_level(key_level),
    .key_press(key_press),
    .key_release(key_release),
    .rst_cnt(rst_cnt)
  );

  always #5 clk = ~clk;

  task automatic modelReset();
    raw1 = '1;
    raw2 = '1;
    for (int j = 0; j < DB; j++) pwin[j] = '0;
    m_level   = '0;
    m_press   = '0;
    m_release = '0;
    streak    = 0;
    m_cnt     = 0;
    m_soc     = 1'b1;
  endtask

  task automatic modelEdge();
    logic [NKEY-1:0] p, old;
    logic            all_diff;
    if (!rst_n) begin
      modelReset();
      return;
    end
    p    = ~raw2;
    raw2 = raw1;
    raw1 = key_in;
    for (int j = DB - 1; j > 0; j--) pwin[j] = pwin[j-1];
    pwin[0] = p;
    old = m_level;
    for (int i = 0; i < NKEY; i++) begin
      all_diff = 1'b1;
      for (int j = 0; j < DB; j++) begin
        if (pwin[j][i] == m_level[i]) all_diff = 1'b0;
      end
      if (all_diff) m_level[i] = ~m_level[i];
    end
    m_press   = m_level & ~old;
    m_release = ~m_level & old;
    if (m_press[RK] && !m_soc && m_cnt < 255) m_cnt++;
    if (!old[RK] && !m_level[RK]) begin
      if (streak < 100000) streak++;
    end else begin
      streak = 0;
    end
    m_soc = (streak < HOLD);
  endtask

  task automatic expectEq(input string tag, input int observed, input int expected);
    checks++;
    assert (observed === expected) else begin
      failures++;
      $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  task automatic checkOutput(input string tag);
    expectEq({tag, ".soc_rst"}, int'(soc_rst), int'(m_soc));
    expectEq({tag, ".key_level"}, int'(key_level), int'(m_level));
    expectEq({tag, ".key_press"}, int'(key_press), int'(m_press));
    expectEq({tag, ".key_release"}, int'(key_release), int'(m_release));
    expectEq({tag, ".rst_cnt"}, int'(rst_cnt), m_cnt);
  endtask

  task automatic applyStimulus(input int n, input string tag);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      #1;
      modelEdge();
      checkOutput(tag);
    end
  endtask

  initial begin
    int e;
    int press_at;
    modelReset();

    // Power-on: reset values, then soc_rst falls at edge HOLD.
    rst_n  = 1'b0;
    key_in = '1;
    applyStimulus(3, "reset");
    expectEq("reset_soc_rst", int'(soc_rst), 1);
    expectEq("reset_key_level", int'(key_level), 0);
    expectEq("reset_rst_cnt", int'(rst_cnt), 0);
    rst_n = 1'b1;
    e = 0;
    while (soc_rst !== 1'b0 && e < 50) begin
      applyStimulus(1, "poweron");
      e++;
    end
    expectEq("poweron_fall_edge", e, HOLD);

    // Bounce filter A: short glitches on key 1 never reach key_level.
    key_in[1] = 1'b0;
    applyStimulus(3, "bounceA");
    key_in[1] = 1'b1;
    applyStimulus(6, "bounceA");
    for (int g = 0; g < 6; g++) begin
      key_in[1] = 1'b0;
      applyStimulus($urandom_range(1, DB - 1), "glitch");
      key_in[1] = 1'b1;
      applyStimulus($urandom_range(1, 6), "glitch");
    end
    applyStimulus(4, "glitch");
    expectEq("bounceA_level1", int'(key_level[1]), 0);

    // Bounce filter B: stable press accepted at edge 5.
    key_in[1] = 1'b0;
    e = -1;
    do begin
      applyStimulus(1, "bounceB");
      e++;
    end while (key_press[1] !== 1'b1 && e < 20);
    expectEq("bounceB_press_edge", e, 5);
    applyStimulus(1, "bounceB");
    expectEq("bounceB_single_pulse", int'(key_press[1]), 0);
    expectEq("bounceB_soc_rst", int'(soc_rst), 0);
    key_in[1] = 1'b1;
    applyStimulus(8, "bounceB_rel");

    // Reset key in RUN: held 20 cycles.
    key_in[0] = 1'b0;
    e = -1;
    do begin
      applyStimulus(1, "rk_press");
      e++;
    end while (key_press[0] !== 1'b1 && e < 20);
    expectEq("rk_press_soc_rst", int'(soc_rst), 1);
    applyStimulus(20 - e - 1, "rk_held");
    key_in[0] = 1'b1;
    e = -1;
    do begin
      applyStimulus(1, "rk_release");
      e++;
    end while (key_release[0] !== 1'b1 && e < 20);
    expectEq("rk_release_edge", e, 5);
    e = 0;
    while (soc_rst !== 1'b0 && e < 50) begin
      applyStimulus(1, "rk_hold");
      e++;
    end
    expectEq("rk_fall_edges", e, HOLD);
    expectEq("rk_rst_cnt", int'(rst_cnt), 1);

    // Key held through power-on.
    rst_n     = 1'b0;
    key_in[0] = 1'b0;
    applyStimulus(3, "held_reset");
    rst_n = 1'b1;
    applyStimulus(30, "held_run");
    expectEq("held_soc_rst", int'(soc_rst), 1);
    key_in[0] = 1'b1;
    e = -1;
    do begin
      applyStimulus(1, "held_release");
      e++;
    end while (key_release[0] !== 1'b1 && e < 20);
    expectEq("held_release_edge", e, 5);
    e = 0;
    while (soc_rst !== 1'b0 && e < 50) begin
      applyStimulus(1, "held_hold");
      e++;
    end
    expectEq("held_fall_edges", e, HOLD);
    expectEq("held_rst_cnt", int'(rst_cnt), 0);

    // Async reset mid-HOLD (count 5) and mid-debounce of key 2.
    rst_n = 1'b0;
    applyStimulus(1, "async_pre");
    rst_n = 1'b1;
    applyStimulus(3, "async_hold");
    key_in[2] = 1'b0;
    applyStimulus(2, "async_hold");
    #2;
    rst_n = 1'b0;
    #1;
    modelReset();
    expectEq("async_soc_rst_now", int'(soc_rst), 1);
    checkOutput("async_now");
    applyStimulus(2, "async_low");
    rst_n = 1'b1;
    e = 0;
    press_at = 0;
    while (soc_rst !== 1'b0 && e < 50) begin
      applyStimulus(1, "async_restart");
      e++;
      if (key_press[2] === 1'b1) press_at = e;
    end
    expectEq("async_fall_edges", e, HOLD);
    expectEq("async_press2_edge", press_at, 6);
    key_in[2] = 1'b1;
    applyStimulus(8, "async_rel");

    // Random activity on the non-reset keys; the FSM must stay in RUN.
    for (int r = 0; r < 60; r++) begin
      key_in[NKEY-1:1] = 3'($urandom);
      applyStimulus($urandom_range(1, 8), "random");
    end
    key_in = '1;
    applyStimulus(8, "random_idle");
    expectEq("random_soc_rst", int'(soc_rst), 0);

    // Counter saturation over 260 key-initiated resets.
    for (int c = 0; c < 260; c++) begin
      key_in[0] = 1'b0;
      key_in[NKEY-1:1] = 3'($urandom);
      applyStimulus(8, "sat_press");
      key_in[0] = 1'b1;
      applyStimulus(16, "sat_release");
    end
    expectEq("sat_rst_cnt", int'(rst_cnt), 255);
    key_in = '1;
    applyStimulus(8, "sat_idle");
    expectEq("sat_rst_cnt_hold", int'(rst_cnt), 255);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/de2_reset_ctrl.md
# de2_reset_ctrl

Board-level reset and push-button controller for the DE2 build of veriRISCV. It synchronizes and debounces the four active-low `KEY` inputs, and sequences the active-high `rst` of `veriRISCV_soc`: hold after power-on, assert while the reset key is held, release after a fixed hold time. It also provides debounced key levels, press/release pulses and a saturating reset counter. These are routed to SoC GPIO inputs or LEDs.

## Interface
- `NKEY`, 4: number of push buttons.
- `DEBOUNCE_CYCLES`, 500000: consecutive stable cycles needed to accept a key change (10 ms at 50 MHz); must be ≥ 2.
- `RESET_HOLD_CYCLES`, 1024: cycles `soc_rst` stays asserted after the reset key is released or after power-on; must be ≥ 1.
- `RESET_KEY`, 0: index of the key that resets the SoC.

Ports:
- `clk`  in  1  system clock (`CLOCK_50`).
- `rst_n`  in  1  asynchronous, active-low block reset (power-on / PLL lock).
- `key_in`  in  NKEY  raw buttons, active-low, asynchronous to `clk`.
- `soc_rst`  out  1  active-high reset to `veriRISCV_soc.rst`.
- `key_level`  out  NKEY  debounced state, 1 = pressed.
- `key_press`  out  NKEY  one-cycle pulse when `key_level` bit rises.
- `key_release`  out  NKEY  one-cycle pulse when `key_level` bit falls.
- `rst_cnt`  out  8  number of key-initiated resets since `rst_n`; saturates at 255.

## Operation
- Reset values: `soc_rst`=1, `key_level`=0, `key_press`=0, `key_release`=0, `rst_cnt`=0, FSM=HOLD, all counters 0, synchronizer flops=1 (released).
- Synchronizer: each key uses 2 flops. `pressed_s[i]` is the inverted output of the second flop.
- Debounce (per key, independent): a counter of width clog2(DEBOUNCE_CYCLES).
  - If `pressed_s[i]` equals `key_level[i]`, the counter clears.
  - Otherwise it increments. On the cycle it would reach DEBOUNCE_CYCLES, `key_level[i]` toggles and the counter clears.
  - `key_press`/`key_release` are registered on the same edge that `key_level` toggles.
- Reset FSM (state registered; `soc_rst` registered from next state):
  - HOLD: `soc_rst`=1.
    - If `key_level[RESET_KEY]`=1, the hold counter clears and the FSM stays.
    - Otherwise the counter increments. When the counter equals RESET_HOLD_CYCLES-1, go to RUN.
  - RUN: `soc_rst`=0. On `key_press[RESET_KEY]`, go to PRESSED and increment `rst_cnt` unless it is 255.
  - PRESSED: `soc_rst`=1. On `key_release[RESET_KEY]`, go to HOLD with the hold counter = 0.
- Non-reset keys never affect the FSM. Their pulses are generated in every state, including while `soc_rst`=1.
- Simultaneous events: a press and a release of the same key in one cycle cannot occur. Different keys toggle independently in the same cycle.
- `rst_n` assertion at any time (mid-debounce, mid-HOLD, in RUN) has these effects:
  - `soc_rst`=1 immediately (asynchronously).
  - All state clears and no pulse is emitted.
  - A key still held at deassertion is re-detected after debounce and produces a `key_press`.

## Timing
- Key latency: if `key_in[i]` changes before edge 0 and stays stable, `pressed_s` changes after edge 1. `key_level[i]`/pulse change at edge 1+DEBOUNCE_CYCLES.
- A raw glitch shorter than DEBOUNCE_CYCLES synchronized cycles produces no output change.
- Power-on with keys released: `rst_n` high before edge 1 → `soc_rst` falls at edge RESET_HOLD_CYCLES.
- RUN→PRESSED: `soc_rst` rises on the same edge `key_press[RESET_KEY]` is 1, with no extra cycle.
- Release: `soc_rst` falls RESET_HOLD_CYCLES edges after the edge on which `key_release[RESET_KEY]` is 1.
- `soc_rst` deasserts synchronously to `clk`. It asserts asynchronously only via `rst_n`.

## Test plan
Parameters for all scenarios: DEBOUNCE_CYCLES=4, RESET_HOLD_CYCLES=8.

- **Power-on**
  - Stimulus: `rst_n`=0 for 3 cycles, all keys high.
  - Required response during reset: `soc_rst`=1, `key_level`=0, `rst_cnt`=0.
  - Required response after release: `soc_rst` falls exactly at edge 8 after `rst_n` rises.
- **Bounce filter**
  - Stimulus A: `key_in[1]` low for 3 cycles, then high. Required: `key_level[1]` stays 0, no pulses.
  - Stimulus B: `key_in[1]` low continuously from before edge 0. Required: `key_level[1]`=1 and a single `key_press[1]` at edge 5.
  - Required in both: `soc_rst` stays 0.
- **Reset key in RUN**
  - Stimulus: `key_in[0]` low 20 cycles, then high.
  - Required:
    - `soc_rst` rises with `key_press[0]` and stays 1 while the key is held.
    - `key_release[0]` appears 5 edges after `key_in[0]` goes high.
    - `soc_rst` falls 8 edges after `key_release[0]`; `rst_cnt`=1.
- **Key held through power-on**
  - Stimulus: `key_in[0]` low before `rst_n` rises, released 30 cycles later.
  - Required: `soc_rst` stays 1 throughout, falls 8 edges after `key_release[0]`; `rst_cnt`=0.
- **Counter saturation**
  - Stimulus: 260 complete press/release cycles of `KEY[0]`.
  - Required: `rst_cnt`=255 and holds; all presses still reset the SoC.
- **Async reset mid-operation**
  - Stimulus: `rst_n` pulsed low mid-HOLD (count 5) and mid-debounce of `key_in[2]`.
  - Required: `soc_rst`=1 within the same cycle; no `key_press[2]` until a full 4-cycle stable window after `rst_n` rises; HOLD restarts from 0 (falls 8 edges later).
